mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Shares the single shift-add multiplier (its control FSM and datapath) between `N_REQ` requesters. Requesters present operands and a level request; the arbiter picks one round-robin, latches its operands, pulses the multiplier start, waits for multiplier done, then returns the product with a one-cycle acknowledge. It sits between the CPU units that need multiplication (ALU, address/MAC helpers) and the multiplier core.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..8)
- `WIDTH`, 16: operand width; product is 2*WIDTH
- `TIMEOUT`, 255: max cycles waiting for `Mul_Done`; used only with `MULT_ARB_TIMEOUT_EN`

Ports (one clock; reset is asynchronous and active-low):
- `Clk` in 1: clock, rising edge
- `Rst_n` in 1: asynchronous active-low reset
- `Req` in N_REQ: per-requester level request; operands held stable while high
- `A_in` in N_REQ*WIDTH: multiplicands, requester i at bits [i*WIDTH +: WIDTH]
- `B_in` in N_REQ*WIDTH: multipliers, same packing
- `Gnt` out N_REQ: one-hot owner of the multiplier, high from selection to Ack
- `Ack` out N_REQ: one-cycle pulse to the owner; `Result` valid this cycle
- `Err` out 1: pulses with `Ack` on timeout (0 without macro)
- `Result` out 2*WIDTH: product register, holds until next Ack
- `Mul_St` out 1: start to multiplier control, one-cycle pulse
- `Mul_A`, `Mul_B` out WIDTH each: latched operands to multiplier datapath
- `Mul_Idle` in 1: multiplier control idle
- `Mul_Done` in 1: multiplier control done pulse
- `Mul_Product` in 2*WIDTH: multiplier product

## Operation
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE: if any `Req` and `Mul_Idle`: select first requesting index searching upward from `ptr` with wrap; register `Gnt`, `Mul_A`, `Mul_B`; go ISSUE. Otherwise stay.
- ISSUE: `Mul_St`=1 for this cycle only; go BUSY.
- BUSY: on `Mul_Done`: `Result`<=`Mul_Product`; go RESP.
- RESP: `Ack[sel]`=1; `Gnt`<=0; `ptr`<=(sel+1) mod N_REQ; go IDLE.
- Requester drops `Req` after grant: transaction still completes and Acks; result discarded by requester.
- Requester must deassert `Req` the cycle after `Ack` or it is re-arbitrated as a new request (subject to round-robin).
- `Mul_Done` outside BUSY is ignored. `Mul_Idle` low in IDLE blocks selection.
- Reset (any state, async): state IDLE, `ptr`=0, all outputs 0 (`Gnt`, `Ack`, `Err`, `Result`, `Mul_St`, `Mul_A`, `Mul_B`). Multiplier core has no reset; its stray `Done` after reset is ignored per above.

## Timing
- Req seen at edge t in IDLE -> `Gnt` and `Mul_St` high in cycle t+1 -> BUSY from t+2.
- `Mul_Done` in cycle d -> `Ack`/`Result` in cycle d+1 -> IDLE d+2; next grant earliest d+3.
- Overhead: 3 cycles plus multiplier latency per transaction.
- Fairness: with all requesters continuously asserting, each is served once per N_REQ transactions.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined: counter cleared on entering BUSY, increments each BUSY cycle; if it reaches `TIMEOUT` without `Mul_Done`, go RESP with `Result`<=0 and `Err`=1 alongside `Ack`. `Mul_Done` on the same cycle as expiry wins (normal completion, no Err).
- Undefined: no counter; BUSY waits indefinitely; `Err` tied 0.

## Structure
- Package `mult_arb_pkg`: state encoding (2-bit, IDLE=0, ISSUE=1, BUSY=2, RESP=3), default widths.
- Sub-module `rr_picker`: combinational round-robin picker (`Req`, `ptr` -> one-hot grant, index, any).

## Test plan
- Single: Req=01, A0=3, B0=5 -> Mul_St pulse one cycle after Req, Ack=01 one cycle after Mul_Done, Result=15.
- Contention: Req=11 from reset -> requester 0 served first (A0=7,B0=6 -> 42), then requester 1 (A1=9,B1=9 -> 81), no back-to-back starvation.
- Fairness: Req=11 held for 4 transactions -> Ack order 0,1,0,1.
- Withdrawal: requester 1 drops Req during BUSY -> Ack[1] still pulses, ptr advances to 0.
- Reset in BUSY: Rst_n low mid-operation -> Gnt=0, Mul_St=0, Result=0 immediately; later stray Mul_Done ignored, no Ack.
- Timeout (macro on, TIMEOUT=10): Mul_Done never asserted -> Ack and Err pulse 10 BUSY cycles in, Result=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier arbiter: FSM state encoding,
// default widths and a pointer-width helper.
package mult_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DEF_N_REQ   = 2;
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 255;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or above the
// pointer, wrapping around, as both a one-hot vector and an index.
module rr_picker
   import mult_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int PTR_W = ptr_width(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_any
);

   logic [PTR_W-1:0] w_j;

   // Scan upward from the pointer; the first hit wins.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_j = PTR_W'((int'(i_ptr) + k) % N_REQ);
         if (!o_any && i_req[w_j]) begin
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
            o_any      = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among N_REQ requesters.
// Optional BUSY watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic [N_REQ-1:0]       Req,
   input  logic [N_REQ*WIDTH-1:0] A_in,
   input  logic [N_REQ*WIDTH-1:0] B_in,
   output logic [N_REQ-1:0]       Gnt,
   output logic [N_REQ-1:0]       Ack,
   output logic                   Err,
   output logic [2*WIDTH-1:0]     Result,
   output logic                   Mul_St,
   output logic [WIDTH-1:0]       Mul_A,
   output logic [WIDTH-1:0]       Mul_B,
   input  logic                   Mul_Idle,
   input  logic                   Mul_Done,
   input  logic [2*WIDTH-1:0]     Mul_Product
);

   localparam int PTR_W = ptr_width(N_REQ);

   state_t               r_state, w_state_nxt;
   logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0]     r_sel, w_sel_nxt;
   logic [N_REQ-1:0]     r_gnt, w_gnt_nxt;
   logic [N_REQ-1:0]     r_ack, w_ack_nxt;
   logic                 r_err, w_err_nxt;
   logic                 r_mul_st, w_mul_st_nxt;
   logic [2*WIDTH-1:0]   r_result, w_result_nxt;
   logic [WIDTH-1:0]     r_mul_a, w_mul_a_nxt;
   logic [WIDTH-1:0]     r_mul_b, w_mul_b_nxt;

   logic [N_REQ-1:0]     w_pick_gnt;
   logic [PTR_W-1:0]     w_pick_idx;
   logic                 w_pick_any;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
`endif

   rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .i_req (Req),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   // Next-state and next-output decode for the arbitration FSM.
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_sel_nxt    = r_sel;
      w_gnt_nxt    = r_gnt;
      w_ack_nxt    = '0;
      w_err_nxt    = 1'b0;
      w_mul_st_nxt = 1'b0;
      w_result_nxt = r_result;
      w_mul_a_nxt  = r_mul_a;
      w_mul_b_nxt  = r_mul_b;
`ifdef MULT_ARB_TIMEOUT_EN
      w_cnt_nxt    = r_cnt;
`endif
      case (r_state)
         IDLE: begin
            if (w_pick_any && Mul_Idle) begin
               w_gnt_nxt    = w_pick_gnt;
               w_sel_nxt    = w_pick_idx;
               w_mul_a_nxt  = A_in[w_pick_idx*WIDTH +: WIDTH];
               w_mul_b_nxt  = B_in[w_pick_idx*WIDTH +: WIDTH];
               w_mul_st_nxt = 1'b1;
               w_state_nxt  = ISSUE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
            w_state_nxt = BUSY;
         end
         BUSY: begin
            // A done coinciding with expiry is treated as a normal completion.
            if (Mul_Done) begin
               w_result_nxt = Mul_Product;
               w_ack_nxt    = r_gnt;
               w_state_nxt  = RESP;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_result_nxt = '0;
               w_ack_nxt    = r_gnt;
               w_err_nxt    = 1'b1;
               w_state_nxt  = RESP;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`else
            else begin
               w_state_nxt = BUSY;
            end
`endif
         end
         RESP: begin
            w_gnt_nxt   = '0;
            w_ptr_nxt   = (r_sel == PTR_W'(N_REQ - 1)) ? '0 : r_sel + PTR_W'(1);
            w_state_nxt = IDLE;
         end
         default: begin
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_sel    <= '0;
         r_gnt    <= '0;
         r_ack    <= '0;
         r_err    <= 1'b0;
         r_mul_st <= 1'b0;
         r_result <= '0;
         r_mul_a  <= '0;
         r_mul_b  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
         r_cnt    <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_sel    <= w_sel_nxt;
         r_gnt    <= w_gnt_nxt;
         r_ack    <= w_ack_nxt;
         r_err    <= w_err_nxt;
         r_mul_st <= w_mul_st_nxt;
         r_result <= w_result_nxt;
         r_mul_a  <= w_mul_a_nxt;
         r_mul_b  <= w_mul_b_nxt;
`ifdef MULT_ARB_TIMEOUT_EN
         r_cnt    <= w_cnt_nxt;
`endif
      end
   end

   assign Gnt    = r_gnt;
   assign Ack    = r_ack;
   assign Err    = r_err;
   assign Result = r_result;
   assign Mul_St = r_mul_st;
   assign Mul_A  = r_mul_a;
   assign Mul_B  = r_mul_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized self-checking bench for mult_arbiter; the bench plays the
// multiplier core and predicts winners from a round-robin reference model.
module tb_mult_arbiter;

   localparam int N  = 2;
   localparam int W  = 16;
   localparam int TO = 10;

   logic             Clk;
   logic             Rst_n;
   logic [N-1:0]     Req;
   logic [N*W-1:0]   A_in;
   logic [N*W-1:0]   B_in;
   logic [N-1:0]     Gnt;
   logic [N-1:0]     Ack;
   logic             Err;
   logic [2*W-1:0]   Result;
   logic             Mul_St;
   logic [W-1:0]     Mul_A;
   logic [W-1:0]     Mul_B;
   logic             Mul_Idle;
   logic             Mul_Done;
   logic [2*W-1:0]   Mul_Product;

   int chk_cnt = 0;
   int err_cnt = 0;

   // Reference model state
   logic [N-1:0]     pend;
   logic [W-1:0]     a_m [N];
   logic [W-1:0]     b_m [N];
   int               ptr_m;

   mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Req         (Req),
      .A_in        (A_in),
      .B_in        (B_in),
      .Gnt         (Gnt),
      .Ack         (Ack),
      .Err         (Err),
      .Result      (Result),
      .Mul_St      (Mul_St),
      .Mul_A       (Mul_A),
      .Mul_B       (Mul_B),
      .Mul_Idle    (Mul_Idle),
      .Mul_Done    (Mul_Done),
      .Mul_Product (Mul_Product)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ops();
      Req = pend;
      for (int i = 0; i < N; i++) begin
         A_in[i*W +: W] = a_m[i];
         B_in[i*W +: W] = b_m[i];
      end
   endtask

   function automatic int winner(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (p[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] e;
      e = {{W{1'b0}}, a};
      return e * {{W{1'b0}}, b};
   endfunction

   task automatic do_reset();
      Rst_n = 1'b0;
      pend  = '0;
      ptr_m = 0;
      Mul_Done = 1'b0;
      Mul_Idle = 1'b1;
      drive_ops();
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
   endtask

   // One full transaction, starting and ending at a negedge in IDLE.
   task automatic do_txn(input int lat, input int stall, input bit withdraw,
                         input bit keep, output logic [N-1:0] ack_seen);
      logic [2*W-1:0] core_p;
      logic [2*W-1:0] exp_p;
      int w;
      drive_ops();
      for (int k = 0; k < stall; k++) begin
         Mul_Idle    = 1'b0;
         Mul_Done    = (k == 0);
         Mul_Product = '1;
         @(negedge Clk);
         check("stall_gnt", Gnt, 0);
         check("stall_ack", Ack, 0);
      end
      Mul_Idle    = 1'b1;
      Mul_Done    = 1'b0;
      Mul_Product = '0;
      w     = winner(pend, ptr_m);
      exp_p = prod(a_m[w], b_m[w]);
      @(negedge Clk);
      check("issue_gnt", Gnt, 64'(1) << w);
      check("issue_st", Mul_St, 1);
      check("issue_a", Mul_A, a_m[w]);
      check("issue_b", Mul_B, b_m[w]);
      core_p = prod(Mul_A, Mul_B);
      if (withdraw) begin
         pend[w] = 1'b0;
         drive_ops();
      end
      @(negedge Clk);
      check("st_pulse", Mul_St, 0);
      for (int k = 0; k < lat; k++) begin
         @(negedge Clk);
         check("busy_ack", Ack, 0);
      end
      Mul_Done    = 1'b1;
      Mul_Product = core_p;
      @(negedge Clk);
      Mul_Done    = 1'b0;
      Mul_Product = '0;
      ack_seen = Ack;
      check("ack", Ack, 64'(1) << w);
      check("result", Result, exp_p);
      check("err", Err, 0);
      if (!keep) pend[w] = 1'b0;
      drive_ops();
      ptr_m = (w + 1) % N;
      @(negedge Clk);
      check("ack_clr", Ack, 0);
      check("gnt_clr", Gnt, 0);
      check("result_hold", Result, exp_p);
   endtask

   initial begin
      logic [N-1:0] ack_v;
      logic [N-1:0] fair_exp;
      Req = '0; A_in = '0; B_in = '0;
      Mul_Idle = 1'b1; Mul_Done = 1'b0; Mul_Product = '0;
      pend = '0; ptr_m = 0;
      for (int i = 0; i < N; i++) begin a_m[i] = '0; b_m[i] = '0; end
      Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_gnt", Gnt, 0);
      check("rst_ack", Ack, 0);
      check("rst_err", Err, 0);
      check("rst_result", Result, 0);
      check("rst_st", Mul_St, 0);
      check("rst_a", Mul_A, 0);
      check("rst_b", Mul_B, 0);
      Rst_n = 1'b1;
      @(negedge Clk);

      // Single requester
      pend = 2'b01; a_m[0] = 16'd3; b_m[0] = 16'd5;
      do_txn(2, 0, 1'b0, 1'b0, ack_v);
      check("single_result", Result, 15);

      // Contention from reset
      do_reset();
      pend = 2'b11; a_m[0] = 16'd7; b_m[0] = 16'd6; a_m[1] = 16'd9; b_m[1] = 16'd9;
      do_txn(1, 0, 1'b0, 1'b0, ack_v);
      check("cont_first", ack_v, 2'b01);
      check("cont_r42", Result, 42);
      do_txn(3, 0, 1'b0, 1'b0, ack_v);
      check("cont_second", ack_v, 2'b10);
      check("cont_r81", Result, 81);

      // Fairness with both requests held
      do_reset();
      pend = 2'b11;
      for (int t = 0; t < 4; t++) begin
         fair_exp = (t % 2 == 0) ? 2'b01 : 2'b10;
         do_txn(t, 0, 1'b0, 1'b1, ack_v);
         check("fair_order", ack_v, fair_exp);
      end

      // Withdrawal by requester 1, pointer then back at 0
      do_reset();
      pend = 2'b10; a_m[1] = 16'd11; b_m[1] = 16'd4;
      do_txn(2, 0, 1'b1, 1'b0, ack_v);
      check("wd_ack", ack_v, 2'b10);
      pend = 2'b11;
      do_txn(1, 0, 1'b0, 1'b0, ack_v);
      check("wd_ptr", ack_v, 2'b01);
      pend = '0;
      drive_ops();

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         int lat, stall;
         bit wd, kp;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i] = 1'b1;
               a_m[i]  = W'($urandom);
               b_m[i]  = W'($urandom);
            end
         end
         if (pend == '0) begin
            int r;
            r = $urandom_range(N - 1, 0);
            pend[r] = 1'b1;
            a_m[r]  = W'($urandom);
            b_m[r]  = W'($urandom);
         end
         lat   = $urandom_range(4, 0);
         stall = $urandom_range(2, 0);
         wd    = ($urandom_range(3, 0) == 0);
         kp    = !wd && ($urandom_range(3, 0) == 0);
         do_txn(lat, stall, wd, kp, ack_v);
      end

      // Reset in BUSY, then a stray done must be ignored
      do_reset();
      pend = 2'b01; a_m[0] = 16'd3; b_m[0] = 16'd5;
      do_txn(0, 0, 1'b0, 1'b0, ack_v);
      pend = 2'b01;
      drive_ops();
      @(negedge Clk);
      @(negedge Clk);
      check("pre_rst_gnt", Gnt, 2'b01);
      Rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", Gnt, 0);
      check("mid_rst_st", Mul_St, 0);
      check("mid_rst_result", Result, 0);
      check("mid_rst_a", Mul_A, 0);
      pend = '0; ptr_m = 0;
      drive_ops();
      @(negedge Clk);
      Rst_n = 1'b1;
      Mul_Done = 1'b1;
      Mul_Product = 32'hDEAD_BEEF;
      @(negedge Clk);
      Mul_Done = 1'b0;
      check("stray_ack", Ack, 0);
      check("stray_result", Result, 0);
      @(negedge Clk);
      check("stray_ack2", Ack, 0);
      check("stray_gnt", Gnt, 0);

`ifdef MULT_ARB_TIMEOUT_EN
      // Watchdog expiry with no done
      pend = 2'b01; a_m[0] = 16'd3; b_m[0] = 16'd5;
      do_txn(1, 0, 1'b0, 1'b0, ack_v);
      pend = 2'b10; a_m[1] = 16'd2; b_m[1] = 16'd2;
      drive_ops();
      @(negedge Clk);
      check("to_st", Mul_St, 1);
      pend = '0;
      drive_ops();
      for (int k = 0; k < TO; k++) begin
         @(negedge Clk);
         check("to_wait_ack", Ack, 0);
      end
      @(negedge Clk);
      check("to_ack", Ack, 2'b10);
      check("to_err", Err, 1);
      check("to_result", Result, 0);
      @(negedge Clk);
      check("to_err_clr", Err, 0);
      check("to_ack_clr", Ack, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
